// File: rtl/tl_get_fragmenter.sv
// tl_get_fragmenter
//   Splits one in-side TileLink-UL Get of up to 2^MAX_SIZE_LOG2 bytes into
//   single-beat out-side Gets of DATA_BYTES each. Each fragment is tagged
//   with its index in the low FRAG_W source bits. The responses come back
//   as an in-order in-side D burst. The block also provides an
//   outstanding-fragment limit, D-order checking with a sticky error flag,
//   and a busy status output.
//
// Handshakes: a beat transfers on a channel in a cycle where valid && ready
//   are both high. valid never waits on ready. The payload holds steady
//   while valid && !ready.
//
// Ports
//   clock, reset          clock; asynchronous active-low reset
//   in_a_*                in-side Get request (valid/ready, size, source,
//                         address, mask)
//   in_d_*                in-side response burst (valid/ready, size,
//                         source, data)
//   out_a_*               out-side single-beat fragment request
//   out_d_*               out-side fragment response
//   busy                  burst being issued or responses outstanding
//   frag_err              sticky D-order / unsolicited-response error
//   dbg_state             current FSM state (0 = IDLE, 1 = ISSUE)
module tl_get_fragmenter #(
    parameter int DATA_BYTES    = 8,
    parameter int MAX_SIZE_LOG2 = 7,
    parameter int SIZE_W        = 3,
    parameter int SRC_W         = 5,
    parameter int ADDR_W        = 17,
    parameter int MAX_INFLIGHT  = 4,
    localparam int BEAT_LOG2    = $clog2(DATA_BYTES),
    localparam int FRAG_W       = MAX_SIZE_LOG2 - BEAT_LOG2,
    localparam int OSRC_W       = SRC_W + FRAG_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_a_valid,
    output logic                    in_a_ready,
    input  logic [SIZE_W-1:0]       in_a_size,
    input  logic [SRC_W-1:0]        in_a_source,
    input  logic [ADDR_W-1:0]       in_a_address,
    input  logic [DATA_BYTES-1:0]   in_a_mask,
    output logic                    in_d_valid,
    input  logic                    in_d_ready,
    output logic [SIZE_W-1:0]       in_d_size,
    output logic [SRC_W-1:0]        in_d_source,
    output logic [8*DATA_BYTES-1:0] in_d_data,
    output logic                    out_a_valid,
    input  logic                    out_a_ready,
    output logic [SIZE_W-1:0]       out_a_size,
    output logic [OSRC_W-1:0]       out_a_source,
    output logic [ADDR_W-1:0]       out_a_address,
    output logic [DATA_BYTES-1:0]   out_a_mask,
    input  logic                    out_d_valid,
    output logic                    out_d_ready,
    input  logic [OSRC_W-1:0]       out_d_source,
    input  logic [8*DATA_BYTES-1:0] out_d_data,
    output logic                    busy,
    output logic                    frag_err,
    output logic                    dbg_state
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAG_W-1:0]       idx_q, idx_d;
    logic [FRAG_W-1:0]       exp_q, exp_d;
    logic [SIZE_W-1:0]       size_q, size_d;
    logic [SRC_W-1:0]        src_q, src_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_BYTES-1:0]   mask_q, mask_d;
    logic                    err_q, err_d;

    logic                    in_a_fire, out_a_fire, d_fire, d_unsol, d_bad;
    logic [FRAG_W-1:0]       last_idx;

    // Index of the final fragment: nfrag-1, or 0 for sub-beat and one-beat Gets.
    always_comb begin
        last_idx = '0;
        if (size_q > SIZE_W'(BEAT_LOG2)) begin
            last_idx = FRAG_W'((32'd1 << (size_q - SIZE_W'(BEAT_LOG2))) - 32'd1);
        end
    end

    assign in_a_ready    = (state_q == ST_IDLE) && (cnt_q == '0);
    assign out_a_valid   = (state_q == ST_ISSUE) && (cnt_q < CNT_W'(MAX_INFLIGHT));
    assign out_a_size    = (size_q > SIZE_W'(BEAT_LOG2)) ? SIZE_W'(BEAT_LOG2) : size_q;
    assign out_a_source  = {src_q, idx_q};
    assign out_a_address = addr_q + (ADDR_W'(idx_q) << BEAT_LOG2);
    assign out_a_mask    = (size_q >= SIZE_W'(BEAT_LOG2)) ? '1 : mask_q;

    // Once nothing is outstanding, any beat is unsolicited. Such a beat is
    // swallowed so it cannot stall the slave, and it is never forwarded.
    assign in_d_valid  = out_d_valid && (cnt_q != '0);
    assign out_d_ready = in_d_ready || (cnt_q == '0);
    assign in_d_source = out_d_source[OSRC_W-1:FRAG_W];
    assign in_d_size   = size_q;
    assign in_d_data   = out_d_data;

    assign in_a_fire  = in_a_valid && in_a_ready;
    assign out_a_fire = out_a_valid && out_a_ready;
    assign d_fire     = out_d_valid && in_d_ready && (cnt_q != '0);
    assign d_unsol    = out_d_valid && (cnt_q == '0);
    assign d_bad      = (out_d_source[FRAG_W-1:0] != exp_q) ||
                        (out_d_source[OSRC_W-1:FRAG_W] != src_q);

    assign busy      = (state_q == ST_ISSUE) || (cnt_q != '0);
    assign frag_err  = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        size_d  = size_q;
        src_d   = src_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_a_fire) begin
                    size_d  = in_a_size;
                    src_d   = in_a_source;
                    addr_d  = in_a_address;
                    mask_d  = in_a_mask;
                    idx_d   = '0;
                    exp_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (out_a_fire) begin
                    idx_d = idx_q + FRAG_W'(1);
                    if (idx_q == last_idx) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept requires zero outstanding, so it never coincides with d_fire.
        if (d_fire) begin
            exp_d = exp_q + FRAG_W'(1);
            if (d_bad) begin
                err_d = 1'b1;
            end
        end
        if (d_unsol) begin
            err_d = 1'b1;
        end

        case ({out_a_fire, d_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            exp_q   <= '0;
            size_q  <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            size_q  <= size_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_tl_get_fragmenter.sv
// tb_tl_get_fragmenter
//   Directed bench for tl_get_fragmenter with default parameters
//   (8-byte beats, 128-byte max Get, 4 fragments in flight).
module tb_tl_get_fragmenter;

    localparam int MAX_INFLIGHT = 4;
    localparam int BUDGET       = 300;

    logic        clock;
    logic        reset;
    logic        in_a_valid;
    logic        in_a_ready;
    logic [2:0]  in_a_size;
    logic [4:0]  in_a_source;
    logic [16:0] in_a_address;
    logic [7:0]  in_a_mask;
    logic        in_d_valid;
    logic        in_d_ready;
    logic [2:0]  in_d_size;
    logic [4:0]  in_d_source;
    logic [63:0] in_d_data;
    logic        out_a_valid;
    logic        out_a_ready;
    logic [2:0]  out_a_size;
    logic [8:0]  out_a_source;
    logic [16:0] out_a_address;
    logic [7:0]  out_a_mask;
    logic        out_d_valid;
    logic        out_d_ready;
    logic [8:0]  out_d_source;
    logic [63:0] out_d_data;
    logic        busy;
    logic        frag_err;
    logic        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] exp_q[$];
    logic [8:0]  exp_src_q[$];

    tl_get_fragmenter dut (
        .clock         (clock),
        .reset         (reset),
        .in_a_valid    (in_a_valid),
        .in_a_ready    (in_a_ready),
        .in_a_size     (in_a_size),
        .in_a_source   (in_a_source),
        .in_a_address  (in_a_address),
        .in_a_mask     (in_a_mask),
        .in_d_valid    (in_d_valid),
        .in_d_ready    (in_d_ready),
        .in_d_size     (in_d_size),
        .in_d_source   (in_d_source),
        .in_d_data     (in_d_data),
        .out_a_valid   (out_a_valid),
        .out_a_ready   (out_a_ready),
        .out_a_size    (out_a_size),
        .out_a_source  (out_a_source),
        .out_a_address (out_a_address),
        .out_a_mask    (out_a_mask),
        .out_d_valid   (out_d_valid),
        .out_d_ready   (out_d_ready),
        .out_d_source  (out_d_source),
        .out_d_data    (out_d_data),
        .busy          (busy),
        .frag_err      (frag_err),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [8:0] s);
        return {23'h0, s, 23'h5A5A5, s};
    endfunction

    // Driver + scoreboard for one Get. Responses come back in issue order,
    // except that swap returns index 1 before index 0. d_delay holds D off
    // for that many cycles after accept. stall randomises both readies.
    task automatic run_get(input logic [2:0] size, input logic [16:0] addr,
                           input logic [4:0] src, input logic [7:0] mask,
                           input int d_delay, input bit swap, input bit stall);
        int          nfrag, issued, rcvd, cyc, sel;
        logic [8:0]  pend_q[$];
        logic [8:0]  dsrc, esrc;
        logic [16:0] eaddr;
        logic        drv;
        nfrag  = (size > 3) ? (1 << (size - 3)) : 1;
        issued = 0;
        rcvd   = 0;
        cyc    = 0;
        sel    = 0;
        exp_q.delete();
        exp_src_q.delete();
        for (int k = 0; k < nfrag; k++) begin
            exp_q.push_back(addr + 17'(k * 8));
            exp_src_q.push_back({src, 4'(k)});
        end

        @(negedge clock);
        in_a_valid   = 1'b1;
        in_a_size    = size;
        in_a_address = addr;
        in_a_source  = src;
        in_a_mask    = mask;
        #1 check_eq("in_a_ready_at_req", in_a_ready, 1);
        @(negedge clock);
        in_a_valid = 1'b0;

        while ((issued < nfrag || rcvd < nfrag) && cyc < BUDGET) begin
            out_a_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_d_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            drv  = 1'b0;
            dsrc = '0;
            if (cyc >= d_delay && pend_q.size() > 0 &&
                !(swap && rcvd == 0 && pend_q.size() < 2)) begin
                drv  = 1'b1;
                sel  = (swap && rcvd == 0) ? 1 : 0;
                dsrc = pend_q[sel];
            end
            out_d_valid  = drv;
            out_d_source = dsrc;
            out_d_data   = beat_data(dsrc);
            #1;
            check_eq("out_a_valid", out_a_valid,
                     (issued < nfrag) && (issued - rcvd < MAX_INFLIGHT));
            check_eq("busy", busy, (issued < nfrag) || (issued != rcvd));
            check_eq("dbg_state", dbg_state, issued < nfrag);
            check_eq("in_d_valid", in_d_valid, drv);
            if (out_a_valid && out_a_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("frag_count", issued + 1, nfrag);
                end else begin
                    eaddr = exp_q.pop_front();
                    esrc  = exp_src_q.pop_front();
                    check_eq("a_address", out_a_address, eaddr);
                    check_eq("a_source", out_a_source, esrc);
                    check_eq("a_size", out_a_size, (size > 3) ? 3 : size);
                    check_eq("a_mask", out_a_mask, (size >= 3) ? 8'hFF : mask);
                    pend_q.push_back(esrc);
                end
                issued++;
            end
            if (drv) begin
                check_eq("out_d_ready", out_d_ready, in_d_ready);
                if (in_d_ready) begin
                    check_eq("d_source", in_d_source, src);
                    check_eq("d_size", in_d_size, size);
                    check_eq("d_data", in_d_data, beat_data(dsrc));
                    pend_q.delete(sel);
                    rcvd++;
                end
            end
            cyc++;
            @(negedge clock);
        end

        out_d_valid = 1'b0;
        out_a_ready = 1'b1;
        in_d_ready  = 1'b1;
        check_eq("burst_in_budget", cyc < BUDGET, 1);
        #1;
        check_eq("in_a_ready_after", in_a_ready, 1);
        check_eq("busy_after", busy, 0);
        check_eq("out_a_valid_after", out_a_valid, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int fires, cyc;
        reset        = 1'b0;
        in_a_valid   = 1'b0;
        in_a_size    = '0;
        in_a_source  = '0;
        in_a_address = '0;
        in_a_mask    = '0;
        in_d_ready   = 1'b1;
        out_a_ready  = 1'b1;
        out_d_valid  = 1'b0;
        out_d_source = '0;
        out_d_data   = '0;
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_in_a_ready", in_a_ready, 1);
        check_eq("rst_out_a_valid", out_a_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_d_valid", in_d_valid, 0);
        check_eq("rst_frag_err", frag_err, 0);
        check_eq("rst_dbg_state", dbg_state, 0);
        @(negedge clock);
        reset = 1'b1;

        // 128-byte Get: 16 fragments 0x1000..0x1078, sources 0x30..0x3F
        run_get(3'd7, 17'h1000, 5'd3, 8'hFF, 0, 1'b0, 1'b0);
        check_eq("err_after_s7", frag_err, 0);
        // sub-beat Get keeps its size and mask
        run_get(3'd2, 17'h0204, 5'd6, 8'hF0, 0, 1'b0, 1'b0);
        check_eq("err_after_s2", frag_err, 0);
        // D held off: 4 issued, then out_a_valid low until responses begin
        run_get(3'd6, 17'h0400, 5'd17, 8'hFF, 12, 1'b0, 1'b0);
        check_eq("err_after_s6", frag_err, 0);
        // random backpressure on both sides
        run_get(3'd5, 17'h0a60, 5'd21, 8'hFF, 0, 1'b0, 1'b1);
        check_eq("err_after_stall", frag_err, 0);
        // responses 1 and 0 swapped: still forwarded, error flagged
        run_get(3'd4, 17'h0310, 5'd9, 8'hFF, 0, 1'b1, 1'b0);
        check_eq("err_after_swap", frag_err, 1);
        run_get(3'd3, 17'h0048, 5'd2, 8'hFF, 0, 1'b0, 1'b0);
        check_eq("err_sticky", frag_err, 1);

        // reset after 3 of 8 fragments issued
        pulse_reset();
        #1 check_eq("err_cleared", frag_err, 0);
        @(negedge clock);
        out_d_valid  = 1'b0;
        in_a_valid   = 1'b1;
        in_a_size    = 3'd6;
        in_a_address = 17'h0800;
        in_a_source  = 5'd9;
        in_a_mask    = 8'hFF;
        #1 check_eq("mid_in_a_ready", in_a_ready, 1);
        @(negedge clock);
        in_a_valid = 1'b0;
        fires = 0;
        cyc   = 0;
        while (fires < 3 && cyc < 50) begin
            #1;
            if (out_a_valid && out_a_ready) fires++;
            cyc++;
            @(negedge clock);
        end
        check_eq("mid_fires", fires, 3);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_out_a_valid", out_a_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_in_a_ready", in_a_ready, 1);
        @(negedge clock);
        reset = 1'b1;
        // late response to an abandoned fragment is unsolicited
        in_d_ready   = 1'b0;
        out_d_valid  = 1'b1;
        out_d_source = {5'd9, 4'd0};
        out_d_data   = beat_data({5'd9, 4'd0});
        #1;
        check_eq("unsol_in_d_valid", in_d_valid, 0);
        check_eq("unsol_out_d_ready", out_d_ready, 1);
        @(negedge clock);
        out_d_valid = 1'b0;
        in_d_ready  = 1'b1;
        #1;
        check_eq("unsol_frag_err", frag_err, 1);
        check_eq("unsol_busy", busy, 0);
        check_eq("unsol_in_a_ready", in_a_ready, 1);

        pulse_reset();
        run_get(3'd3, 17'h0100, 5'd12, 8'hFF, 0, 1'b0, 1'b0);
        check_eq("err_after_recover", frag_err, 0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_get_fragmenter.md
Name: tl_get_fragmenter

Overview:
- Parametrised TileLink-UL Get fragmenter that sits between a crossbar-side client port (in) and a narrow slave port (out).
- Splits one in-side Get of up to 2^MAX_SIZE_LOG2 bytes into single-beat out-side Gets of DATA_BYTES each.
- Tags each fragment with its index in the low source bits and reassembles the responses into an in-order in-side D burst.
- Adds behaviour the previous fixed coupler lacked: a configurable outstanding-fragment limit, D-order checking with a sticky error flag, and a busy status output.

Parameters:
- DATA_BYTES, 8, beat width in bytes (power of 2); BEAT_LOG2 = log2(DATA_BYTES).
- MAX_SIZE_LOG2, 7, largest accepted in-side transfer, log2 bytes; FRAG_W = MAX_SIZE_LOG2 - BEAT_LOG2.
- SIZE_W, 3, width of the in-side size field.
- SRC_W, 5, in-side source width; out-side source width is SRC_W+FRAG_W.
- ADDR_W, 17, address width.
- MAX_INFLIGHT, 4, maximum out-side fragments issued but not yet answered (1..2^FRAG_W).

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_a_valid  in  1  in-side Get request valid
- in_a_ready  out  1  in-side Get accept
- in_a_size  in  SIZE_W  log2 bytes requested
- in_a_source  in  SRC_W  request id
- in_a_address  in  ADDR_W  byte address, aligned to 2^size
- in_a_mask  in  DATA_BYTES  byte lanes, meaningful for sub-beat requests only
- in_d_valid  out  1  response beat valid
- in_d_ready  in  1  response beat accept
- in_d_size  out  SIZE_W  original request size
- in_d_source  out  SRC_W  original request id
- in_d_data  out  8*DATA_BYTES  response data
- out_a_valid  out  1  fragment request valid
- out_a_ready  in  1  fragment accept
- out_a_size  out  SIZE_W  fragment size
- out_a_source  out  SRC_W+FRAG_W  {in source, fragment index}
- out_a_address  out  ADDR_W  fragment address
- out_a_mask  out  DATA_BYTES  fragment lanes
- out_d_valid  in  1  fragment response valid
- out_d_ready  out  1  fragment response accept
- out_d_source  in  SRC_W+FRAG_W  fragment response id
- out_d_data  in  8*DATA_BYTES  fragment response data
- busy  out  1  burst in progress or responses outstanding
- frag_err  out  1  sticky D-order or unsolicited-response error

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, outstanding=0, issue index=0, expected index=0, frag_err=0.
  - Resulting outputs: in_a_ready=1, out_a_valid=0, busy=0, in_d_valid=0 while out_d_valid=0.
- States: IDLE, ISSUE.
- in_a_ready = (state==IDLE) && (outstanding==0).
- Accept (in_a fire) latches size, source, address, mask; clears the issue index and expected index; moves to ISSUE.
- Fragment count nfrag = 2^(size-BEAT_LOG2) if size>BEAT_LOG2, else 1. Sizes above MAX_SIZE_LOG2 are illegal; behaviour on them is undefined.
- ISSUE: out_a_valid = (outstanding < MAX_INFLIGHT). First out_a_valid is 1 cycle after accept (registered).
  - Fragment k: address = base + k*DATA_BYTES, source = {src, k[FRAG_W-1:0]}.
  - size = min(size, BEAT_LOG2); mask = all-ones if size>=BEAT_LOG2, else latched mask.
- Each out_a fire increments k. The fire with k==nfrag-1 returns to IDLE.
- outstanding: +1 on out_a fire, -1 on out_d fire, unchanged when both occur in the same cycle. It never exceeds MAX_INFLIGHT.
- D path is combinational, zero latency:
  - in_d_valid = out_d_valid && outstanding!=0.
  - out_d_ready = in_d_ready || outstanding==0.
  - in_d_source = out_d_source upper SRC_W bits; in_d_size = latched size; in_d_data = out_d_data.
- On each out_d fire with outstanding!=0:
  - If the low FRAG_W bits != expected index, or the upper bits != latched source, set frag_err. The beat is still forwarded.
  - Expected index increments on every such fire.
- Unsolicited response (out_d_valid with outstanding==0): beat is consumed and dropped (in_d_valid=0); frag_err is set.
- frag_err clears only on reset.
- busy = (state==ISSUE) || (outstanding!=0).
- Reset mid-burst abandons all fragments. Any response arriving later is treated as unsolicited.
- Held in_a or out_d stalls never drop or duplicate fragments. Output payloads stay stable while valid && !ready.

Test Plan:
- size=7, addr=0x1000, src=3, out_a_ready=1, in-order D → 16 fragments at 0x1000,0x1008..0x1078; out source 0x30..0x3F; 16 in_d beats with size=7, src=3; in_a_ready returns 1 after the last in_d fire; frag_err=0.
- size=2, addr=0x204, mask=0xF0 → exactly one fragment with size=2, mask=0xF0, source {src,0}; one in_d beat.
- size=6, out_d_valid held 0 → exactly MAX_INFLIGHT=4 fragments issued, then out_a_valid=0 until the first response; burst completes after 8 responses.
- Two D responses swapped (indices 1 then 0) → both forwarded; frag_err=1 and stays 1 until reset.
- out_d_valid=1 with no request → out_d_ready=1, in_d_valid=0, frag_err=1.
- Reset asserted after 3 of 8 fragments issued → next cycle out_a_valid=0, busy=0, in_a_ready=1; a new size=3 Get then completes normally.
